// File: rtl/audio_adc_rx_if.sv
// audio_adc_rx_if: valid/ready stream carrying stereo frames {left, right}.
interface audio_adc_rx_if #(parameter int DATA_WIDTH = 16);
  logic [2*DATA_WIDTH-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S frame-master ADC receiver with a stereo-frame FIFO.
// Optional AUDIO_ADC_RX_DEBUG_EN drives the scope debug copies.
module audio_adc_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN = 250,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset_n,
  output logic aud_adclrck,
  input logic aud_adcdat,
  audio_adc_rx_if.master rx,
  output logic overflow,
  input logic overflow_clr,
  output logic debug_adclrck,
  output logic debug_adcdat
);
  localparam int H = FRAME_LEN / 2;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W = 2 * DATA_WIDTH;
  typedef enum logic [2:0] {WAIT_L, SHIFT_L, WAIT_R, SHIFT_R, PUSH} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] sh, sh_nxt, left;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  logic shift, push, pop, full, wr_en, drop;
  assign cnt_nxt = (cnt == CW'(FRAME_LEN - 1)) ? '0 : cnt + 1'b1;
  assign sh_nxt = {sh[DATA_WIDTH-2:0], aud_adcdat};
  assign shift = (state == SHIFT_L) || (state == SHIFT_R);
  assign push = state == PUSH;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = rx.rx_valid && rx.rx_ready;
  assign wr_en = push && (!full || pop);
  assign drop = push && full && !pop;
  assign rx.rx_valid = count != '0;
  assign rx.rx_data = mem[rd];
  always_comb begin
    nxt = state;
    case (state)
      WAIT_L: nxt = (cnt == '0) ? SHIFT_L : WAIT_L;
      SHIFT_L: nxt = (cnt == CW'(DATA_WIDTH)) ? WAIT_R : SHIFT_L;
      WAIT_R: nxt = (cnt == CW'(H)) ? SHIFT_R : WAIT_R;
      SHIFT_R: nxt = (cnt == CW'(H + DATA_WIDTH)) ? PUSH : SHIFT_R;
      default: nxt = WAIT_L;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= WAIT_L;
      cnt <= '0;
      aud_adclrck <= 1'b0;
      sh <= '0;
      left <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      aud_adclrck <= cnt_nxt >= CW'(H);
      sh <= shift ? sh_nxt : sh;
      left <= (state == SHIFT_L && cnt == CW'(DATA_WIDTH)) ? sh_nxt : left;
    end
  end
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) mem[wr] <= {left, sh};
      wr <= wr_en ? wr + 1'b1 : wr;
      rd <= pop ? rd + 1'b1 : rd;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow <= drop ? 1'b1 : overflow_clr ? 1'b0 : overflow;
    end
  end
`ifdef AUDIO_ADC_RX_DEBUG_EN
  logic dat_q;
  always_ff @(posedge clk) dat_q <= !reset_n ? 1'b0 : aud_adcdat;
  assign debug_adclrck = aud_adclrck;
  assign debug_adcdat = dat_q;
`else
  assign debug_adclrck = 1'b0;
  assign debug_adcdat = 1'b0;
`endif
endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: directed checks of frame capture, FIFO, overflow and reset.
module tb_audio_adc_rx;
  logic clk = 0, reset_n = 0, aud_adcdat = 0, overflow_clr = 0;
  logic aud_adclrck, overflow, debug_adclrck, debug_adcdat;
  int ph = 0, fidx = 0, total = 0, bad = 0;
  logic [15:0] tl [64];
  logic [15:0] tr [64];
  audio_adc_rx_if #(.DATA_WIDTH(16)) rx_if ();
  audio_adc_rx dut (
    .clk(clk), .reset_n(reset_n), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
    .rx(rx_if), .overflow(overflow), .overflow_clr(overflow_clr),
    .debug_adclrck(debug_adclrck), .debug_adcdat(debug_adcdat)
  );
  always #5 clk = ~clk;
  // Reference frame counter: the bench's own view of where the frame is.
  always @(posedge clk) begin
    if (!reset_n) begin
      ph <= 0;
      fidx <= fidx + 1;
    end else if (ph == 249) begin
      ph <= 0;
      fidx <= fidx + 1;
    end else ph <= ph + 1;
  end
  always @(negedge clk) begin
    if (ph >= 1 && ph <= 16) aud_adcdat = tl[fidx[5:0]][4'(16 - ph)];
    else if (ph >= 126 && ph <= 141) aud_adcdat = tr[fidx[5:0]][4'(141 - ph)];
    else aud_adcdat = 1'($urandom_range(0, 1));
  end
  function automatic logic [31:0] fr(int n);
    return {tl[n % 64], tr[n % 64]};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_ph(int n);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (ph != n && b < 400);
    if (ph != n) begin
      total++;
      bad++;
      $error("FAIL wait_ph got=%0d exp=%0d", ph, n);
    end
  endtask
  initial begin
    int a, b, c, tog, low;
    logic prev, dbg_exp;
    int exp_q [3];
    for (int i = 0; i < 64; i++) begin
      tl[i] = 16'(i * 997 + 16'h03C1);
      tr[i] = ~16'(i * 613 + 5);
    end
    rx_if.rx_ready = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("rst_lrck", 32'(aud_adclrck), 0);
    chk("rst_valid", 32'(rx_if.rx_valid), 0);
    chk("rst_data", rx_if.rx_data, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_dbg_lrck", 32'(debug_adclrck), 0);
    chk("rst_dbg_dat", 32'(debug_adcdat), 0);
    tl[fidx[5:0]] = 16'hA5C3;
    tr[fidx[5:0]] = 16'h0F0F;
    rx_if.rx_ready = 1;
    wait_ph(142);
    chk("first_valid_142", 32'(rx_if.rx_valid), 0);
    wait_ph(143);
    chk("first_valid_143", 32'(rx_if.rx_valid), 1);
    chk("first_data", rx_if.rx_data, 32'hA5C3_0F0F);
    wait_ph(144);
    chk("first_valid_144", 32'(rx_if.rx_valid), 0);
    wait_ph(200);
`ifdef AUDIO_ADC_RX_DEBUG_EN
    dbg_exp = 1'b1;
`else
    dbg_exp = 1'b0;
`endif
    chk("dbg_lrck_hi", 32'(debug_adclrck), 32'(dbg_exp));
    wait_ph(0);
    prev = aud_adclrck;
    tog = 0;
    low = 0;
    repeat (750) begin
      @(negedge clk);
      if (aud_adclrck !== prev) tog++;
      prev = aud_adclrck;
      if (aud_adclrck === 1'b0) low++;
    end
    chk("lrck_toggles", 32'(tog), 6);
    chk("lrck_low", 32'(low), 375);
    rx_if.rx_ready = 0;
    a = fidx;
    for (int j = 0; j < 4; j++) begin
      wait_ph(143);
      if (j == 0) chk("fill_head", rx_if.rx_data, fr(a));
      if (j == 3) chk("fill_ovf", 32'(overflow), 0);
    end
    wait_ph(143);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_head_stable", rx_if.rx_data, fr(a));
    wait_ph(10);
    overflow_clr = 1;
    wait_ph(11);
    overflow_clr = 0;
    chk("clr_ovf", 32'(overflow), 0);
    wait_ph(142);
    rx_if.rx_ready = 1;
    wait_ph(143);
    rx_if.rx_ready = 0;
    chk("poppush_ovf", 32'(overflow), 0);
    chk("poppush_head", rx_if.rx_data, fr(a + 1));
    wait_ph(142);
    overflow_clr = 1;
    wait_ph(143);
    overflow_clr = 0;
    chk("set_wins", 32'(overflow), 1);
    wait_ph(150);
    overflow_clr = 1;
    wait_ph(151);
    overflow_clr = 0;
    chk("clr_alone", 32'(overflow), 0);
    wait_ph(160);
    chk("drain_head0", rx_if.rx_data, fr(a + 1));
    rx_if.rx_ready = 1;
    exp_q = '{a + 2, a + 3, a + 5};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("drain_valid", 32'(rx_if.rx_valid), 1);
      chk("drain_data", rx_if.rx_data, fr(exp_q[j]));
    end
    @(negedge clk);
    chk("drain_empty", 32'(rx_if.rx_valid), 0);
    wait_ph(0);
    rx_if.rx_ready = 0;
    b = fidx;
    wait_ph(143);
    chk("pre_rst_valid", 32'(rx_if.rx_valid), 1);
    chk("pre_rst_data", rx_if.rx_data, fr(b));
    wait_ph(60);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk("mid_rst_valid", 32'(rx_if.rx_valid), 0);
    chk("mid_rst_data", rx_if.rx_data, 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_lrck", 32'(aud_adclrck), 0);
    c = fidx;
    wait_ph(142);
    chk("post_rst_142", 32'(rx_if.rx_valid), 0);
    wait_ph(143);
    chk("post_rst_valid", 32'(rx_if.rx_valid), 1);
    chk("post_rst_data", rx_if.rx_data, fr(c));
    @(negedge clk);
    chk("post_rst_hold", rx_if.rx_data, fr(c));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
